// File: rtl/entry_controller.sv
// entry_controller: sequences the keypad encoder and the countdown timer.
// Accepted BCD key presses shift into a 3-digit M:SS entry register. The start,
// stop and clear buttons and the door switch drive an ENTRY/RUNNING/PAUSED FSM
// that loads the timer, runs it and gates the magnetron.
//
// Key handshake: valid_data is a level held for as long as a key is down. A
// digit is taken only on its rising edge, so there is one digit per press
// however long the key is held, and the key must be released for at least one
// cycle before the next digit can be taken. No ready/acknowledge signal goes
// back to the encoder. Instead, enablen gates the encoder so that key presses
// can only arrive in ENTRY.
module entry_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] bcd,
    input  logic       valid_data,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       timer_done,
    output logic       enablen,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       load,
    output logic       timer_enable,
    output logic       magnetron_on,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] min_ones_next;
    logic [3:0] sec_tens_next;
    logic [3:0] sec_ones_next;
    logic       load_next;

    logic valid_q;
    logic startn_q;
    logic stopn_q;
    logic clearn_q;

    logic key_event;
    logic start_event;
    logic stop_event;
    logic clear_event;
    logic digits_zero;
    logic start_ok;

    // Edge-detect history. These registers follow their inputs during reset
    // as well, so an input that is held through reset gives no event.
    always_ff @(posedge clock) begin
        valid_q  <= valid_data;
        startn_q <= startn;
        stopn_q  <= stopn;
        clearn_q <= clearn;
    end

    assign key_event   = valid_data & ~valid_q;
    assign start_event = startn_q & ~startn;
    assign stop_event  = stopn_q & ~stopn;
    assign clear_event = clearn_q & ~clearn;

    assign digits_zero = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign start_ok    = door_closed && !digits_zero && (sec_tens <= 4'd5);

    // Next-state and entry-register update. A start event in ENTRY takes
    // precedence over a key event in the same cycle, so that key is dropped.
    always_comb begin
        state_next    = state;
        min_ones_next = min_ones;
        sec_tens_next = sec_tens;
        sec_ones_next = sec_ones;
        load_next     = 1'b0;
        case (state)
            ENTRY: begin
                if (clear_event || stop_event) begin
                    min_ones_next = 4'd0;
                    sec_tens_next = 4'd0;
                    sec_ones_next = 4'd0;
                end else if (start_event) begin
                    if (start_ok) begin
                        load_next  = 1'b1;
                        state_next = RUNNING;
                    end
                end else if (key_event && (bcd <= 4'd9)) begin
                    min_ones_next = sec_tens;
                    sec_tens_next = sec_ones;
                    sec_ones_next = bcd;
                end
            end
            RUNNING: begin
                if (timer_done) begin
                    min_ones_next = 4'd0;
                    sec_tens_next = 4'd0;
                    sec_ones_next = 4'd0;
                    state_next    = ENTRY;
                end else if (stop_event || !door_closed) begin
                    state_next = PAUSED;
                end
            end
            PAUSED: begin
                if (stop_event || clear_event) begin
                    min_ones_next = 4'd0;
                    sec_tens_next = 4'd0;
                    sec_ones_next = 4'd0;
                    state_next    = ENTRY;
                end else if (start_event && door_closed) begin
                    state_next = RUNNING;
                end
            end
            default: begin
                min_ones_next = 4'd0;
                sec_tens_next = 4'd0;
                sec_ones_next = 4'd0;
                state_next    = ENTRY;
            end
        endcase
    end

    // State, digits and registered outputs. The outputs are decoded from the
    // next state so that they change on the same edge as the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ENTRY;
            min_ones     <= 4'd0;
            sec_tens     <= 4'd0;
            sec_ones     <= 4'd0;
            load         <= 1'b0;
            enablen      <= 1'b0;
            timer_enable <= 1'b0;
            magnetron_on <= 1'b0;
        end else begin
            state        <= state_next;
            min_ones     <= min_ones_next;
            sec_tens     <= sec_tens_next;
            sec_ones     <= sec_ones_next;
            load         <= load_next;
            enablen      <= (state_next != ENTRY);
            timer_enable <= (state_next == RUNNING);
            magnetron_on <= (state_next == RUNNING);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_entry_controller.sv
// tb_entry_controller: directed scenarios plus a randomized run. Every cycle is
// checked against a behavioural model that treats the entry as a number from
// 0 to 999.
module tb_entry_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] bcd;
    logic       valid_data;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       timer_done;
    logic       enablen;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       load;
    logic       timer_enable;
    logic       magnetron_on;
    logic [1:0] fsm_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Clock
    always #5 clock = ~clock;

    entry_controller dut (
        .clock        (clock),
        .reset        (reset),
        .bcd          (bcd),
        .valid_data   (valid_data),
        .startn       (startn),
        .stopn        (stopn),
        .clearn       (clearn),
        .door_closed  (door_closed),
        .timer_done   (timer_done),
        .enablen      (enablen),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .load         (load),
        .timer_enable (timer_enable),
        .magnetron_on (magnetron_on),
        .fsm_state    (fsm_state)
    );

    // Reference model. The entry is an integer M*100 + S*10 + s.
    int value;
    bit running;
    bit paused;
    bit exp_load;
    bit p_valid;
    bit p_startn;
    bit p_stopn;
    bit p_clearn;

    // Advance the model by one clock, using the inputs that are present now.
    task model_update();
        bit kev;
        bit sev;
        bit tev;
        bit cev;
        kev = valid_data & ~p_valid;
        sev = p_startn & ~startn;
        tev = p_stopn & ~stopn;
        cev = p_clearn & ~clearn;
        exp_load = 1'b0;
        if (reset) begin
            value   = 0;
            running = 1'b0;
            paused  = 1'b0;
        end else if (!running && !paused) begin
            if (cev || tev) begin
                value = 0;
            end else if (sev) begin
                if (door_closed && value != 0 && ((value / 10) % 10) <= 5) begin
                    exp_load = 1'b1;
                    running  = 1'b1;
                end
            end else if (kev && bcd <= 9) begin
                value = (value * 10 + int'(bcd)) % 1000;
            end
        end else if (running) begin
            if (timer_done) begin
                value   = 0;
                running = 1'b0;
            end else if (tev || !door_closed) begin
                running = 1'b0;
                paused  = 1'b1;
            end
        end else begin
            if (tev || cev) begin
                value  = 0;
                paused = 1'b0;
            end else if (sev && door_closed) begin
                paused  = 1'b0;
                running = 1'b1;
            end
        end
        p_valid  = valid_data;
        p_startn = startn;
        p_stopn  = stopn;
        p_clearn = clearn;
    endtask

    function automatic logic [15:0] model_vec();
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        m = 4'(value / 100);
        t = 4'((value / 10) % 10);
        o = 4'(value % 10);
        return {running | paused, m, t, o, exp_load, running, running};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {enablen, min_ones, sec_tens, sec_ones, load, timer_enable, magnetron_on};
    endfunction

    // Driver tasks
    task cyc();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task do_reset();
        reset       = 1'b1;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        valid_data  = 1'b0;
        bcd         = 4'd0;
        timer_done  = 1'b0;
        door_closed = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    // Hold the key for 3 cycles, then release it for 1 cycle.
    task press_key(input logic [3:0] k);
        valid_data = 1'b1;
        bcd        = k;
        cyc();
        cyc();
        cyc();
        valid_data = 1'b0;
        cyc();
    endtask

    task test_reset();
        startn      = 1'b0;
        stopn       = 1'b1;
        clearn      = 1'b1;
        valid_data  = 1'b1;
        bcd         = 4'd5;
        door_closed = 1'b1;
        timer_done  = 1'b0;
        reset       = 1'b1;
        cyc();
        cyc();
        tests_run++;
        if (dut_vec() !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected 0000", dut_vec());
        end
        reset = 1'b0;
        cyc();
        cyc();
        tests_run++;
        if (dut_vec() !== 16'h0000) begin
            tests_failed++;
            $display("FAIL held_key_through_reset: got %h expected 0000", dut_vec());
        end
        valid_data = 1'b0;
        cyc();
        press_key(4'd2);
        tests_run++;
        if ({enablen, load, min_ones, sec_tens, sec_ones} !== {1'b0, 1'b0, 12'h002}) begin
            tests_failed++;
            $display("FAIL held_start_through_reset: got en=%b ld=%b %h%h%h expected en=0 ld=0 002",
                     enablen, load, min_ones, sec_tens, sec_ones);
        end
        startn = 1'b1;
        cyc();
    endtask

    task test_digit_entry();
        do_reset();
        press_key(4'd1);
        tests_run++;
        if ({min_ones, sec_tens, sec_ones} !== 12'h001) begin
            tests_failed++;
            $display("FAIL first_digit: got %h%h%h expected 001", min_ones, sec_tens, sec_ones);
        end
        press_key(4'd3);
        press_key(4'd0);
        tests_run++;
        if ({min_ones, sec_tens, sec_ones, enablen} !== {12'h130, 1'b0}) begin
            tests_failed++;
            $display("FAIL digit_entry_130: got %h%h%h en=%b expected 130 en=0",
                     min_ones, sec_tens, sec_ones, enablen);
        end
    endtask

    task test_start_run_done();
        startn = 1'b0;
        cyc();
        tests_run++;
        if ({load, timer_enable, magnetron_on, enablen} !== 4'b1111) begin
            tests_failed++;
            $display("FAIL start_accept: got ld/te/mag/en=%b%b%b%b expected 1111",
                     load, timer_enable, magnetron_on, enablen);
        end
        startn = 1'b1;
        cyc();
        tests_run++;
        if ({load, timer_enable, min_ones, sec_tens, sec_ones} !== {2'b01, 12'h130}) begin
            tests_failed++;
            $display("FAIL load_one_cycle: got ld=%b te=%b %h%h%h expected ld=0 te=1 130",
                     load, timer_enable, min_ones, sec_tens, sec_ones);
        end
        timer_done = 1'b1;
        cyc();
        timer_done = 1'b0;
        tests_run++;
        if (dut_vec() !== 16'h0000) begin
            tests_failed++;
            $display("FAIL timer_done_to_entry: got %h expected 0000", dut_vec());
        end
    endtask

    task test_rejected_start();
        do_reset();
        startn = 1'b0;
        cyc();
        tests_run++;
        if (dut_vec() !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reject_zero: got %h expected 0000", dut_vec());
        end
        startn = 1'b1;
        cyc();
        press_key(4'd7);
        press_key(4'd5);
        startn = 1'b0;
        cyc();
        tests_run++;
        if (dut_vec() !== 16'h0075 << 3) begin
            tests_failed++;
            $display("FAIL reject_sec_tens_7: got %h expected %h", dut_vec(), 16'h0075 << 3);
        end
        startn = 1'b1;
        cyc();
        clearn = 1'b0;
        cyc();
        clearn = 1'b1;
        cyc();
        tests_run++;
        if ({min_ones, sec_tens, sec_ones} !== 12'h000) begin
            tests_failed++;
            $display("FAIL clear_entry: got %h%h%h expected 000", min_ones, sec_tens, sec_ones);
        end
        press_key(4'd3);
        press_key(4'd0);
        door_closed = 1'b0;
        startn      = 1'b0;
        cyc();
        tests_run++;
        if (dut_vec() !== 16'h0030 << 3) begin
            tests_failed++;
            $display("FAIL reject_door_open: got %h expected %h", dut_vec(), 16'h0030 << 3);
        end
        startn = 1'b1;
        cyc();
        door_closed = 1'b1;
        cyc();
    endtask

    task test_pause_resume();
        startn = 1'b0;
        cyc();
        startn = 1'b1;
        cyc();
        door_closed = 1'b0;
        cyc();
        tests_run++;
        if ({magnetron_on, timer_enable, enablen, load} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL door_open_pause: got mag/te/en/ld=%b%b%b%b expected 0010",
                     magnetron_on, timer_enable, enablen, load);
        end
        door_closed = 1'b1;
        cyc();
        startn = 1'b0;
        cyc();
        startn = 1'b1;
        tests_run++;
        if ({magnetron_on, timer_enable, enablen, load} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL resume_no_load: got mag/te/en/ld=%b%b%b%b expected 1110",
                     magnetron_on, timer_enable, enablen, load);
        end
        cyc();
        stopn = 1'b0;
        cyc();
        stopn = 1'b1;
        cyc();
        stopn = 1'b0;
        cyc();
        stopn = 1'b1;
        tests_run++;
        if (dut_vec() !== 16'h0000) begin
            tests_failed++;
            $display("FAIL stop_in_paused: got %h expected 0000", dut_vec());
        end
        cyc();
    endtask

    task test_simultaneous();
        do_reset();
        press_key(4'd4);
        press_key(4'd5);
        startn     = 1'b0;
        valid_data = 1'b1;
        bcd        = 4'd9;
        cyc();
        tests_run++;
        if ({timer_enable, load, min_ones, sec_tens, sec_ones} !== {2'b11, 12'h045}) begin
            tests_failed++;
            $display("FAIL start_with_key: got te=%b ld=%b %h%h%h expected te=1 ld=1 045",
                     timer_enable, load, min_ones, sec_tens, sec_ones);
        end
        startn     = 1'b1;
        valid_data = 1'b0;
        cyc();
        timer_done = 1'b1;
        stopn      = 1'b0;
        cyc();
        tests_run++;
        if (dut_vec() !== 16'h0000) begin
            tests_failed++;
            $display("FAIL done_with_stop: got %h expected 0000", dut_vec());
        end
        timer_done = 1'b0;
        stopn      = 1'b1;
        cyc();
    endtask

    task test_reset_running();
        do_reset();
        press_key(4'd1);
        startn = 1'b0;
        cyc();
        startn = 1'b1;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        tests_run++;
        if (dut_vec() !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_in_running: got %h expected 0000", dut_vec());
        end
        cyc();
    endtask

    task test_random();
        logic [15:0] exp_v;
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            startn      = ($urandom_range(0, 5) != 0);
            stopn       = ($urandom_range(0, 11) != 0);
            clearn      = ($urandom_range(0, 11) != 0);
            door_closed = ($urandom_range(0, 9) != 0);
            timer_done  = ($urandom_range(0, 15) == 0);
            valid_data  = 1'($urandom_range(0, 1));
            bcd         = 4'($urandom_range(0, 15));
            cyc();
            exp_v = model_vec();
            tests_run++;
            if (dut_vec() !== exp_v) begin
                tests_failed++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec(), exp_v);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        bcd         = 4'd0;
        valid_data  = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;
        timer_done  = 1'b0;
        value       = 0;
        running     = 1'b0;
        paused      = 1'b0;
        exp_load    = 1'b0;
        p_valid     = 1'b0;
        p_startn    = 1'b1;
        p_stopn     = 1'b1;
        p_clearn    = 1'b1;
        cyc();
        test_reset();
        test_digit_entry();
        test_start_run_done();
        test_rejected_start();
        test_pause_resume();
        test_simultaneous();
        test_reset_running();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
